wb_req_buffer: RTL and testbench
================================

// Module: wb_req_buffer
// PURPOSE
//  Single-clock Wishbone request buffer: pipelined B4 slave port (stall) on the master side, classic B3 master port on the slave side.
//  Queues up to DEPTH requests, replays them one at a time downstream, and returns ack/err in order.
//  Adds a per-access watchdog that returns err on a hung slave.
//  Sits between a pipelined core bus and slow classic peripherals in the wb_intercon fabric.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width; multiple of 8
//  DEPTH    4   request FIFO entries; power of two, >=2
//  TIMEOUT  255 max slave wait cycles before err; 0 disables the watchdog
// PORTS
//  wb_clk       in   1         clock; all logic on rising edge
//  wb_rst_n     in   1         asynchronous reset, active low
//  wbm_adr_i    in   AW        request address
//  wbm_dat_i    in   DW        write data
//  wbm_sel_i    in   DW/8      byte selects
//  wbm_we_i     in   1         write enable
//  wbm_cyc_i    in   1         bus cycle; low = abort/flush
//  wbm_stb_i    in   1         request strobe
//  wbm_stall_o  out  1         request not accepted this cycle
//  wbm_dat_o    out  DW        read data, valid with ack
//  wbm_ack_o    out  1         one-cycle response pulse
//  wbm_err_o    out  1         one-cycle error pulse
//  wbs_adr_o    out  AW        downstream address
//  wbs_dat_o    out  DW        downstream write data
//  wbs_sel_o    out  DW/8      downstream byte selects
//  wbs_we_o     out  1         downstream write enable
//  wbs_cyc_o    out  1         downstream cycle
//  wbs_stb_o    out  1         downstream strobe; always equals wbs_cyc_o
//  wbs_dat_i    in   DW        downstream read data
//  wbs_ack_i    in   1         downstream ack
//  wbs_err_i    in   1         downstream err
//  pending_o    out  clog2(DEPTH+1)+1  queued plus in-flight request count
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty. FSM IDLE. Watchdog counter 0.
//  Accept: wbm_cyc_i & wbm_stb_i & ~wbm_stall_o pushes {adr,dat,sel,we}.
//  Stall: wbm_stall_o = (fifo count == DEPTH), driven from registered count; no combinational path from wbs_*.
//  FSM states:
//   IDLE  -> ISSUE when the FIFO is non-empty; pops the head into the output registers.
//   ISSUE -> wbs_cyc_o/stb_o high with registered adr/dat/sel/we.
//    - On wbs_ack_i or wbs_err_i: -> IDLE, or -> ISSUE directly with the next entry if the FIFO is non-empty.
//    - Back-to-back issue leaves no idle cycle, but wbs_stb_o drops for 1 cycle between accesses (classic cycle termination).
//   Watchdog: counts ISSUE cycles. When count == TIMEOUT with no ack/err, drop wbs_cyc_o and return err.
//  Latency:
//   - Request accepted in cycle N on an empty buffer -> wbs_stb_o high in N+1.
//   - wbs_ack_i in cycle M -> wbm_ack_o in M+1, with wbm_dat_o = wbs_dat_i registered at M.
//  Response rules:
//   - ack and err are mutually exclusive; err wins if wbs_ack_i & wbs_err_i.
//   - wbm_dat_o = 0 on err.
//   - Responses are returned strictly in request order.
//  Simultaneous push and pop: allowed; count unchanged. Push while full is impossible (stalled).
//  FIFO pointers wrap modulo DEPTH, using an extra MSB for full/empty.
//  pending_o = fifo count + (state==ISSUE); max DEPTH+1.
//  Abort: wbm_cyc_i low in any cycle:
//   - flush the FIFO;
//   - next cycle wbs_cyc_o/stb_o = 0, FSM -> IDLE, watchdog cleared;
//   - an in-flight slave response that cycle is discarded; no ack/err is emitted.
//  Reset mid-operation: asynchronous clear to reset state. Any downstream access is cut immediately.
// STRUCTURE
//  wb_intercon_pkg (shared header): FSM state localparams S_IDLE/S_ISSUE, and the CLOG2 function used for count widths.
//  Sub-module wb_sync_fifo (single-clock FIFO with count, flush, async active-low reset); WIDTH = AW+DW+DW/8+1.
//  Top contains the FSM, watchdog counter, response registers and pending count.
// TESTING
//  1 Single read, slave acks after 3 cycles, adr 0x1000, dat 0xDEADBEEF -> wbm_ack_o exactly once, 1 cycle after wbs_ack_i, wbm_dat_o=0xDEADBEEF.
//  2 Burst of 6 writes with DEPTH=4 and a slave that never stalls:
//    -> wbm_stall_o high once 4 entries are queued; all 6 reach wbs_* in order with correct sel; 6 acks; pending_o returns to 0.
//  3 Slave never acks, TIMEOUT=8 -> wbs_cyc_o drops after 8 cycles; wbm_err_o pulses once; the next queued request issues.
//  4 Slave asserts ack and err together -> wbm_err_o=1, wbm_ack_o=0, wbm_dat_o=0.
//  5 Queue 3 requests, drop wbm_cyc_i during the 1st access:
//    -> FIFO flushed; wbs_cyc_o=0 next cycle; no ack/err; pending_o=0.
//  6 Assert wb_rst_n=0 mid-ISSUE -> all outputs 0 asynchronously; after release, a fresh read completes normally.

Source files
------------

// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the wb_intercon fabric blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//   state_t : request-buffer FSM encoding (S_IDLE, S_ISSUE)
//   CLOG2   : ceiling log2 for sizing counters and pointers
package wb_intercon_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Latency: pushed word is visible at dat_o on the cycle after the push.
// Backpressure: full_o from registered pointers; push while full is dropped.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_i            : empties the FIFO on the next edge (wins over push/pop)
//   push_i, dat_i      : write strobe and data
//   pop_i, dat_o       : read strobe and head-of-queue data (show-ahead)
//   count_o            : entries held, 0..DEPTH
//   empty_o, full_o    : status decoded from count_o
module wb_sync_fifo
  import wb_intercon_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dat_o,
  output logic [CLOG2(DEPTH):0]    count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PW = CLOG2(DEPTH);

  // Pointers carry one extra MSB so full and empty stay distinguishable.
  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (PW+1)'(DEPTH));
  assign dat_o   = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i && !full_o) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_d = rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !flush_i) begin
      mem_q[wr_q[PW-1:0]] <= dat_i;
    end
  end

endmodule

// File: rtl/wb_req_buffer.sv
// Wishbone request buffer: pipelined B4 slave in, classic B3 master out, in-order responses, watchdog.
// Latency: accept on empty buffer -> wbs_stb_o next cycle; wbs_ack_i/err_i -> wbm_ack_o/err_o next cycle.
// Backpressure: wbm_stall_o when DEPTH requests are queued (registered, no path from wbs_*).
//   wb_clk, wb_rst_n        : clock, async active-low reset
//   wbm_*                   : upstream pipelined port; wbm_cyc_i low flushes everything
//   wbs_*                   : downstream classic port, one access at a time
//   pending_o               : queued plus in-flight request count
module wb_req_buffer
  import wb_intercon_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst_n,
  input  logic [AW-1:0]             wbm_adr_i,
  input  logic [DW-1:0]             wbm_dat_i,
  input  logic [DW/8-1:0]           wbm_sel_i,
  input  logic                      wbm_we_i,
  input  logic                      wbm_cyc_i,
  input  logic                      wbm_stb_i,
  output logic                      wbm_stall_o,
  output logic [DW-1:0]             wbm_dat_o,
  output logic                      wbm_ack_o,
  output logic                      wbm_err_o,
  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  output logic [DW/8-1:0]           wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  input  logic [DW-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  output logic [CLOG2(DEPTH+1):0]   pending_o
);

  localparam int SW        = DW / 8;
  localparam int EW        = AW + DW + SW + 1;
  localparam int CW        = CLOG2(DEPTH) + 1;
  localparam int PNW       = CLOG2(DEPTH+1) + 1;
  localparam int WDW       = (TIMEOUT > 0) ? CLOG2(TIMEOUT+1) : 1;
  localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WDW-1:0] WD_LAST = WD_LAST_I[WDW-1:0];

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic [EW-1:0]   ent_q, ent_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdat_q, rdat_d;

  logic            accept;
  logic            bypass;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic [EW-1:0]   req_ent;
  logic [EW-1:0]   fifo_dout;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_empty;
  logic            fifo_full;
  logic            timeout_hit;
  logic            slave_err;

  assign req_ent    = {wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i};
  assign accept     = wbm_cyc_i & wbm_stb_i & ~fifo_full;
  assign fifo_push  = accept & ~bypass;
  assign fifo_flush = ~wbm_cyc_i;

  wb_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk),
    .rst_ni  (wb_rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .dat_i   (req_ent),
    .pop_i   (fifo_pop),
    .dat_o   (fifo_dout),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Watchdog fires on the TIMEOUT-th cycle of an unanswered strobe, so the
  // strobe is held for exactly TIMEOUT cycles before the error is returned.
  assign timeout_hit = (TIMEOUT != 0) && cyc_q && (wd_q == WD_LAST);
  // A timeout only counts as an error when the slave did not ack that cycle.
  assign slave_err   = wbs_err_i | (timeout_hit & ~wbs_ack_i);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    ent_d    = ent_q;
    wd_d     = wd_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = '0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;

    if (!wbm_cyc_i) begin
      // Abort: drop the downstream access and any response arriving now.
      state_d = S_IDLE;
      cyc_d   = 1'b0;
      wd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            ent_d    = fifo_dout;
            cyc_d    = 1'b1;
            wd_d     = '0;
            state_d  = S_ISSUE;
          end else if (accept) begin
            // Empty buffer: issue straight from the bus to save a cycle.
            bypass  = 1'b1;
            ent_d   = req_ent;
            cyc_d   = 1'b1;
            wd_d    = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!cyc_q) begin
            // One-cycle strobe gap between back-to-back accesses ends here.
            cyc_d = 1'b1;
            wd_d  = '0;
          end else if (wbs_ack_i || wbs_err_i || timeout_hit) begin
            err_d  = slave_err;
            ack_d  = ~slave_err;
            rdat_d = slave_err ? '0 : wbs_dat_i;
            cyc_d  = 1'b0;
            wd_d   = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              ent_d    = fifo_dout;
            end else begin
              state_d = S_IDLE;
            end
          end else if (TIMEOUT != 0) begin
            wd_d = wd_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cyc_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      ent_q   <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ent_q   <= ent_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o} = ent_q;
  assign wbs_cyc_o   = cyc_q;
  assign wbs_stb_o   = cyc_q;
  assign wbm_ack_o   = ack_q;
  assign wbm_err_o   = err_q;
  assign wbm_dat_o   = rdat_q;
  assign wbm_stall_o = fifo_full;
  assign pending_o   = PNW'(fifo_cnt) + PNW'(state_q == S_ISSUE);

endmodule

// File: tb/tb_wb_req_buffer.sv
module tb_wb_req_buffer;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_HANG = 3;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } req_t;

  typedef struct {
    int          kind;
    int          delay;
    logic [31:0] data;
  } plan_t;

  logic        wb_clk;
  logic        wb_rst_n;
  logic [31:0] wbm_adr_i;
  logic [31:0] wbm_dat_i;
  logic [3:0]  wbm_sel_i;
  logic        wbm_we_i;
  logic        wbm_cyc_i;
  logic        wbm_stb_i;
  logic        wbm_stall_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_o;
  logic        wbm_err_o;
  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_err_i;
  logic [3:0]  pending_o;

  wb_req_buffer #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .wbm_adr_i   (wbm_adr_i),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_sel_i   (wbm_sel_i),
    .wbm_we_i    (wbm_we_i),
    .wbm_cyc_i   (wbm_cyc_i),
    .wbm_stb_i   (wbm_stb_i),
    .wbm_stall_o (wbm_stall_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_o   (wbm_ack_o),
    .wbm_err_o   (wbm_err_o),
    .wbs_adr_o   (wbs_adr_o),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_sel_o   (wbs_sel_o),
    .wbs_we_o    (wbs_we_o),
    .wbs_cyc_o   (wbs_cyc_o),
    .wbs_stb_o   (wbs_stb_o),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_i   (wbs_ack_i),
    .wbs_err_i   (wbs_err_i),
    .pending_o   (pending_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: requests accepted but not yet started, and the
  // externally visible bus behaviour expected for the next cycle.
  req_t        req_q[$];
  plan_t       plan_q[$];
  int          pend     = 0;
  bit          cyc_exp  = 0;
  bit          prev_cyc = 0;
  bit          exp_ack  = 0;
  bit          exp_err  = 0;
  logic [31:0] exp_dat  = '0;
  int          hicnt    = 0;
  int          pl_kind  = K_ACK;
  int          pl_delay = 0;
  logic [31:0] pl_data  = '0;
  int          n_ack    = 0;
  int          n_err    = 0;
  bit          stall_seen = 0;
  logic [31:0] last_ack_dat = '0;
  logic [31:0] last_err_dat = '0;

  task automatic pick_plan();
    plan_t p;
    int r;
    if (plan_q.size() != 0) begin
      p = plan_q.pop_front();
    end else begin
      r = $urandom_range(0, 19);
      p.kind  = (r == 0) ? K_HANG : (r < 3) ? K_ERR : (r == 3) ? K_BOTH : K_ACK;
      p.delay = $urandom_range(0, 3);
      p.data  = $urandom();
    end
    pl_kind  = p.kind;
    pl_delay = p.delay;
    pl_data  = p.data;
  endtask

  task automatic check_cycle();
    req_t r;
    chk("wbs_cyc", wbs_cyc_o, cyc_exp);
    chk("wbs_stb", wbs_stb_o, cyc_exp);
    chk("wbm_ack", wbm_ack_o, exp_ack);
    chk("wbm_err", wbm_err_o, exp_err);
    if (exp_ack || exp_err) chk("wbm_dat", wbm_dat_o, exp_dat);
    chk("pending", pending_o, pend);
    chk("stall", wbm_stall_o, (pend == DEPTH + 1));
    if (wbm_ack_o) begin n_ack++; last_ack_dat = wbm_dat_o; end
    if (wbm_err_o) begin n_err++; last_err_dat = wbm_dat_o; end
    if (wbm_stall_o) stall_seen = 1;
    if (cyc_exp) begin
      if (!prev_cyc) begin
        chk("req_avail", (req_q.size() != 0), 1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          chk("wbs_adr", wbs_adr_o, r.adr);
          chk("wbs_wdat", wbs_dat_o, r.dat);
          chk("wbs_sel", wbs_sel_o, r.sel);
          chk("wbs_we", wbs_we_o, r.we);
        end
        pick_plan();
        hicnt = 1;
      end else begin
        hicnt++;
      end
    end
  endtask

  // One clock: slave reacts, model advances, then outputs are checked.
  task automatic step();
    bit sa, se, tmo, acc, term;
    req_t r;
    sa = 0; se = 0; tmo = 0;
    if (cyc_exp) begin
      if (hicnt - 1 == pl_delay) begin
        sa = (pl_kind == K_ACK) || (pl_kind == K_BOTH);
        se = (pl_kind == K_ERR) || (pl_kind == K_BOTH);
      end
      tmo = !sa && !se && (hicnt == TIMEOUT);
    end
    wbs_ack_i = sa;
    wbs_err_i = se;
    wbs_dat_i = sa ? pl_data : $urandom();
    exp_ack = 0; exp_err = 0; exp_dat = '0;
    prev_cyc = cyc_exp;
    if (!wbm_cyc_i) begin
      req_q.delete();
      pend    = 0;
      cyc_exp = 0;
    end else begin
      acc  = wbm_stb_i && (pend != DEPTH + 1);
      term = cyc_exp && (sa || se || tmo);
      if (acc) begin
        r = '{adr: wbm_adr_i, dat: wbm_dat_i, sel: wbm_sel_i, we: wbm_we_i};
        req_q.push_back(r);
        pend++;
      end
      if (term) begin
        pend--;
        exp_err = se || tmo;
        exp_ack = !(se || tmo);
        exp_dat = exp_ack ? pl_data : 32'h0;
      end
      cyc_exp = !term && (cyc_exp || pend > 0);
    end
    @(negedge wb_clk);
    check_cycle();
  endtask

  task automatic drive_req(input logic [31:0] adr, input logic we);
    wbm_cyc_i = 1; wbm_stb_i = 1;
    wbm_adr_i = adr; wbm_we_i = we;
    wbm_dat_i = $urandom(); wbm_sel_i = 4'($urandom_range(1, 15));
  endtask

  task automatic idle(input int n);
    wbm_cyc_i = 1; wbm_stb_i = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_clear();
    req_q.delete(); plan_q.delete();
    pend = 0; cyc_exp = 0; prev_cyc = 0;
    exp_ack = 0; exp_err = 0; exp_dat = '0; hicnt = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_cyc"}, wbs_cyc_o, 0);
    chk({tag, "_stb"}, wbs_stb_o, 0);
    chk({tag, "_ack"}, wbm_ack_o, 0);
    chk({tag, "_err"}, wbm_err_o, 0);
    chk({tag, "_stall"}, wbm_stall_o, 0);
    chk({tag, "_pend"}, pending_o, 0);
    chk({tag, "_rdat"}, wbm_dat_o, 0);
    chk({tag, "_adr"}, wbs_adr_o, 0);
  endtask

  int a0, e0, cnt, guard;
  bit ok;

  initial begin
    wb_rst_n  = 0;
    wbm_cyc_i = 0; wbm_stb_i = 0; wbm_we_i = 0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbs_ack_i = 0; wbs_err_i = 0; wbs_dat_i = '0;
    @(negedge wb_clk);
    reset_checks("reset");
    @(negedge wb_clk);
    wb_rst_n = 1;
    model_clear();

    // 1: single read, slave acks on its 4th strobe cycle
    a0 = n_ack;
    plan_q.push_back('{K_ACK, 3, 32'hDEADBEEF});
    drive_req(32'h1000, 0);
    step();
    idle(10);
    chk("t1_acks", n_ack - a0, 1);
    chk("t1_dat", last_ack_dat, 32'hDEADBEEF);

    // 2: six writes into a four-deep queue
    a0 = n_ack; stall_seen = 0; cnt = 0; guard = 0;
    for (int i = 0; i < 6; i++) plan_q.push_back('{K_ACK, 2, $urandom()});
    while (cnt < 6 && guard < 100) begin
      drive_req(32'h2000 + 32'(cnt * 4), 1);
      ok = !wbm_stall_o;
      step();
      if (ok) cnt++;
      guard++;
    end
    chk("t2_accepted", cnt, 6);
    idle(40);
    chk("t2_stall_seen", stall_seen, 1);
    chk("t2_acks", n_ack - a0, 6);
    chk("t2_pend", pending_o, 0);

    // 3: hung slave times out, next request still served
    a0 = n_ack; e0 = n_err;
    plan_q.push_back('{K_HANG, 0, 32'h0});
    plan_q.push_back('{K_ACK, 1, 32'hCAFE0003});
    drive_req(32'h3000, 0); step();
    drive_req(32'h3004, 0); step();
    idle(25);
    chk("t3_errs", n_err - e0, 1);
    chk("t3_acks", n_ack - a0, 1);

    // 4: ack and err together
    a0 = n_ack; e0 = n_err;
    plan_q.push_back('{K_BOTH, 1, 32'h55AA55AA});
    drive_req(32'h4000, 0); step();
    idle(6);
    chk("t4_errs", n_err - e0, 1);
    chk("t4_acks", n_ack - a0, 0);
    chk("t4_dat", last_err_dat, 0);

    // 5: abort during the first of three accesses, as the slave answers
    a0 = n_ack; e0 = n_err;
    plan_q.push_back('{K_ACK, 3, 32'h0BAD0BAD});
    for (int i = 0; i < 3; i++) begin
      drive_req(32'h5000 + 32'(i * 4), 1); step();
    end
    idle(1);
    wbm_cyc_i = 0; wbm_stb_i = 0;
    step();
    chk("t5_cyc", wbs_cyc_o, 0);
    plan_q.delete();
    idle(10);
    chk("t5_resp", (n_ack - a0) + (n_err - e0), 0);
    chk("t5_pend", pending_o, 0);

    // 6: reset in the middle of an access, then a fresh read
    plan_q.push_back('{K_ACK, 6, 32'h0});
    drive_req(32'h6000, 0); step();
    idle(3);
    chk("t6_busy", wbs_cyc_o, 1);
    wbs_ack_i = 0; wbs_err_i = 0;
    #2 wb_rst_n = 0;
    #1 reset_checks("t6_rst");
    @(negedge wb_clk);
    wb_rst_n = 1;
    model_clear();
    a0 = n_ack;
    plan_q.push_back('{K_ACK, 1, 32'h12345678});
    drive_req(32'h6100, 0); step();
    idle(8);
    chk("t6_acks", n_ack - a0, 1);
    chk("t6_dat", last_ack_dat, 32'h12345678);

    // random traffic with occasional aborts, hangs and errors
    for (int i = 0; i < 3000; i++) begin
      wbm_cyc_i = ($urandom_range(0, 59) != 0);
      wbm_stb_i = ($urandom_range(0, 2) != 0);
      wbm_adr_i = $urandom(); wbm_dat_i = $urandom();
      wbm_sel_i = 4'($urandom()); wbm_we_i = 1'($urandom());
      step();
    end
    idle(80);
    chk("drain_pend", pending_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
